// File: rtl/prim_param_store_pkg.sv
// Shared definitions for the PVR per-primitive parameter store: word layout
// indices, the store FSM encoding and a word-index helper.
package pvr_param_pkg;

  localparam int DEF_HDR_WORDS  = 3;
  localparam int DEF_VERT_WORDS = 7;

  // Header word indices
  localparam int ISP = 0;
  localparam int TSP = 1;
  localparam int TCW = 2;

  // Field offsets within one vertex
  localparam int X          = 0;
  localparam int Y          = 1;
  localparam int Z          = 2;
  localparam int U0         = 3;
  localparam int V0         = 4;
  localparam int BASE_COL_0 = 5;
  localparam int OFF_COL    = 6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } store_state_e;

  function automatic int word_idx(input int vert, input int field,
                                  input int hdr_words  = DEF_HDR_WORDS,
                                  input int vert_words = DEF_VERT_WORDS);
    return hdr_words + vert * vert_words + field;
  endfunction

endpackage

// File: rtl/prim_param_store_if.sv
// Writer/reader handshake bundle for prim_param_store; master is the
// parser/rasteriser side, slave is the store.
interface prim_param_store_if #(
  parameter int TAG_W = 12,
  parameter int DW    = 768
);
  logic             clear;
  logic             busy;
  logic             wr_valid;
  logic             wr_ready;
  logic [TAG_W-1:0] wr_tag;
  logic [DW-1:0]    wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [TAG_W-1:0] rd_tag;
  logic             out_valid;
  logic             out_hit;
  logic [TAG_W-1:0] out_tag;
  logic [DW-1:0]    out_data;

  modport master (
    output clear, wr_valid, wr_tag, wr_data, rd_valid, rd_tag,
    input  busy, wr_ready, rd_ready, out_valid, out_hit, out_tag, out_data
  );

  modport slave (
    input  clear, wr_valid, wr_tag, wr_data, rd_valid, rd_tag,
    output busy, wr_ready, rd_ready, out_valid, out_hit, out_tag, out_data
  );
endinterface

// File: rtl/prim_param_store_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Contents are deliberately not reset; read-during-write returns old data.
module prim_param_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/prim_param_store.sv
// Per-primitive parameter store: tag-indexed data RAM plus valid bits, with
// write-first bypass, a 2-stage read pipeline and a valid-clearing sweep.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_SWEEP | clearing valid[sweep_cnt] each cycle, ports not ready, busy
// ST_IDLE  | accepting reads and writes; clear starts a new sweep
module prim_param_store
  import pvr_param_pkg::*;
#(
  parameter int TAG_W      = 12,
  parameter int ENTRIES    = 1024,
  parameter int HDR_WORDS  = 3,
  parameter int NUM_VERTS  = 3,
  parameter int VERT_WORDS = 7
) (
  input logic              clock,
  input logic              reset_n,
  prim_param_store_if.slave bus
);

  localparam int WORDS = HDR_WORDS + NUM_VERTS * VERT_WORDS;
  localparam int DW    = 32 * WORDS;
  localparam int AW    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  localparam logic [TAG_W:0] ENT_L = (TAG_W + 1)'(ENTRIES);
  localparam logic [AW-1:0]  LAST  = AW'(ENTRIES - 1);

  store_state_e  state;
  logic [AW-1:0] sweep_cnt;
  logic          busy_q;
  logic          ready_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_SWEEP;
      sweep_cnt <= '0;
      busy_q    <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.clear) begin
            state     <= ST_SWEEP;
            sweep_cnt <= '0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        ST_SWEEP: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state     <= ST_SWEEP;
          sweep_cnt <= '0;
          busy_q    <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  logic          wr_acc, rd_acc;
  logic          wr_in, rd_in;
  logic          byp;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          sweeping;

  assign sweeping = (state == ST_SWEEP);
  assign wr_acc   = bus.wr_valid & ready_q;
  assign rd_acc   = bus.rd_valid & ready_q;
  assign wr_in    = {1'b0, bus.wr_tag} < ENT_L;
  assign rd_in    = {1'b0, bus.rd_tag} < ENT_L;
  assign wr_addr  = wr_in ? bus.wr_tag[AW-1:0] : '0;
  assign rd_addr  = rd_in ? bus.rd_tag[AW-1:0] : '0;
  assign byp      = wr_acc & wr_in & rd_acc & rd_in & (bus.wr_tag == bus.rd_tag);

  // The sweep owns the valid-RAM write port; no writes are accepted meanwhile
  logic          v_we;
  logic [AW-1:0] v_waddr;
  logic          v_wdata;
  logic          v_q;
  logic [DW-1:0] d_q;

  assign v_we    = sweeping | (wr_acc & wr_in);
  assign v_waddr = sweeping ? sweep_cnt : wr_addr;
  assign v_wdata = ~sweeping;

  prim_param_ram #(.W(DW), .DEPTH(ENTRIES), .AW(AW)) u_data_ram (
    .clock (clock),
    .we    (wr_acc & wr_in),
    .waddr (wr_addr),
    .wdata (bus.wr_data),
    .re    (rd_acc),
    .raddr (rd_addr),
    .rdata (d_q)
  );

  prim_param_ram #(.W(1), .DEPTH(ENTRIES), .AW(AW)) u_valid_ram (
    .clock (clock),
    .we    (v_we),
    .waddr (v_waddr),
    .wdata (v_wdata),
    .re    (rd_acc),
    .raddr (rd_addr),
    .rdata (v_q)
  );

  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_in;
  logic             s1_byp;
  logic [DW-1:0]    s1_byp_data;
  logic             s1_hit;

  logic             out_valid_q;
  logic             out_hit_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [DW-1:0]    out_data_q;

  always_ff @(posedge clock) begin
    if (byp) s1_byp_data <= bus.wr_data;
  end

  assign s1_hit = s1_byp | (s1_in & v_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_tag      <= '0;
      s1_in       <= 1'b0;
      s1_byp      <= 1'b0;
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_tag <= bus.rd_tag;
        s1_in  <= rd_in;
        s1_byp <= byp;
      end
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_tag_q  <= s1_tag;
        out_hit_q  <= s1_hit;
        out_data_q <= !s1_hit ? '0 : (s1_byp ? s1_byp_data : d_q);
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.wr_ready  = ready_q;
  assign bus.rd_ready  = ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_hit   = out_hit_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_prim_param_store.sv
// Directed bench for prim_param_store: a 1024-entry triangle store and a
// 1000-entry quad store share one stimulus bus, selected by sel.
module tb_prim_param_store;
  import pvr_param_pkg::*;

  localparam int DWA = 768;
  localparam int DWB = 992;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            rst_a, rst_b, sel;
  logic            clear, wr_valid, rd_valid;
  logic [11:0]     wr_tag, rd_tag;
  logic [DWB-1:0]  wr_data;
  logic            o_busy, o_wready, o_rready, o_valid, o_hit;
  logic [11:0]     o_tag;
  logic [DWB-1:0]  o_data;
  int              n_chk = 0;
  int              n_pass = 0;

  prim_param_store_if #(.TAG_W(12), .DW(DWA)) ia ();
  prim_param_store_if #(.TAG_W(12), .DW(DWB)) ib ();

  prim_param_store #(.TAG_W(12), .ENTRIES(1024), .HDR_WORDS(3), .NUM_VERTS(3),
                     .VERT_WORDS(7)) dut_a (.clock(clock), .reset_n(rst_a), .bus(ia));
  prim_param_store #(.TAG_W(12), .ENTRIES(1000), .HDR_WORDS(3), .NUM_VERTS(4),
                     .VERT_WORDS(7)) dut_b (.clock(clock), .reset_n(rst_b), .bus(ib));

  assign ia.clear    = clear & ~sel;
  assign ia.wr_valid = wr_valid & ~sel;
  assign ia.wr_tag   = wr_tag;
  assign ia.wr_data  = wr_data[DWA-1:0];
  assign ia.rd_valid = rd_valid & ~sel;
  assign ia.rd_tag   = rd_tag;
  assign ib.clear    = clear & sel;
  assign ib.wr_valid = wr_valid & sel;
  assign ib.wr_tag   = wr_tag;
  assign ib.wr_data  = wr_data;
  assign ib.rd_valid = rd_valid & sel;
  assign ib.rd_tag   = rd_tag;

  assign o_busy   = sel ? ib.busy      : ia.busy;
  assign o_wready = sel ? ib.wr_ready  : ia.wr_ready;
  assign o_rready = sel ? ib.rd_ready  : ia.rd_ready;
  assign o_valid  = sel ? ib.out_valid : ia.out_valid;
  assign o_hit    = sel ? ib.out_hit   : ia.out_hit;
  assign o_tag    = sel ? ib.out_tag   : ia.out_tag;
  assign o_data   = sel ? ib.out_data  : {{(DWB-DWA){1'b0}}, ia.out_data};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [11:0] t, input logic [DWB-1:0] d);
    wr_valid = 1'b1;
    wr_tag   = t;
    wr_data  = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  // Any write set up by the caller is presented in the same cycle as the read
  task automatic rd_chk(input string tag, input logic [11:0] t, input logic exp_hit,
                        input logic [DWB-1:0] exp_d, input int widx);
    rd_valid = 1'b1;
    rd_tag   = t;
    cyc();
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(o_valid), 64'd0);
    cyc();
    chk({tag, "_valid"}, 64'(o_valid), 64'd1);
    chk({tag, "_hit"}, 64'(o_hit), 64'(exp_hit));
    chk({tag, "_tag"}, 64'(o_tag), 64'(t));
    chk({tag, "_word"}, 64'(o_data[32*widx +: 32]), 64'(exp_d[32*widx +: 32]));
    chk({tag, "_data"}, 64'(o_data == exp_d), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int exp_n, input logic pulse_clear);
    int  n;
    logic seen_valid;
    n = 0;
    seen_valid = 1'b0;
    while (o_busy && n < 3000) begin
      if (pulse_clear && n == 10) clear = 1'b1;
      cyc();
      clear = 1'b0;
      if (o_valid) seen_valid = 1'b1;
      n++;
    end
    chk({tag, "_cycles"}, 64'(n), 64'(exp_n));
    chk({tag, "_noval"}, 64'(seen_valid), 64'd0);
    chk({tag, "_ready"}, 64'(o_wready & o_rready), 64'd1);
  endtask

  initial begin
    logic [DWB-1:0] d;
    sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0; clear = 1'b0;
    wr_valid = 1'b0; rd_valid = 1'b0; wr_tag = '0; rd_tag = '0; wr_data = '0;

    #12;
    chk("rst_busy", 64'(o_busy), 64'd1);
    chk("rst_ready", 64'(o_wready | o_rready), 64'd0);
    chk("rst_oval", 64'(o_valid), 64'd0);
    chk("rst_hit", 64'(o_hit), 64'd0);
    chk("rst_tag", 64'(o_tag), 64'd0);
    chk("rst_data", 64'(o_data == '0), 64'd1);
    #10 rst_a = 1'b1;

    wait_idle("sweep_a", 1024, 1'b0);
    rd_chk("miss5", 12'd5, 1'b0, '0, 0);

    d = '0;
    for (int k = 0; k < 24; k++) d[32*k +: 32] = 32'hA000 + k;
    wr(12'h010, d);
    rd_chk("wr_rd", 12'h010, 1'b1, d, 3);

    d = '0;
    for (int k = 0; k < 24; k++) d[32*k +: 32] = 32'h5555_5555;
    wr_valid = 1'b1; wr_tag = 12'd7; wr_data = d;
    rd_chk("bypass", 12'd7, 1'b1, d, 0);
    cyc();
    rd_chk("bypass_again", 12'd7, 1'b1, d, 23);

    d = '0; d[31:0] = 32'h11;
    wr(12'd1, d);
    d = '0; d[31:0] = 32'h22;
    wr(12'd2, d);
    rd_valid = 1'b1; rd_tag = 12'd1;
    cyc();
    rd_valid = 1'b0; clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("inflight_valid", 64'(o_valid), 64'd1);
    chk("inflight_hit", 64'(o_hit), 64'd1);
    chk("inflight_word", 64'(o_data[31:0]), 64'h11);
    chk("clear_busy", 64'(o_busy), 64'd1);
    wait_idle("sweep_clr", 1024, 1'b1);
    rd_chk("clr1", 12'd1, 1'b0, '0, 0);
    rd_chk("clr2", 12'd2, 1'b0, '0, 0);

    sel = 1'b1;
    @(negedge clock);
    rst_b = 1'b1;
    wait_idle("sweep_b", 1000, 1'b0);

    d = '1;
    wr(12'd1000, d);
    rd_chk("oor1000", 12'd1000, 1'b0, '0, 0);
    wr(12'd1029, d);
    rd_chk("oor_alias5", 12'd5, 1'b0, '0, 0);

    for (int i = 0; i < 10; i++) begin
      d = '0; d[31:0] = 32'h100 + i;
      wr(12'(i), d);
    end
    for (int i = 0; i < 12; i++) begin
      rd_valid = (i < 10);
      rd_tag   = 12'(i);
      cyc();
      if (i >= 1 && i <= 10) begin
        chk($sformatf("b2b%0d_valid", i - 1), 64'(o_valid), 64'd1);
        chk($sformatf("b2b%0d_tag", i - 1), 64'(o_tag), 64'(i - 1));
        chk($sformatf("b2b%0d_word", i - 1), 64'(o_data[31:0]), 64'(32'h100 + i - 1));
      end
    end
    rd_valid = 1'b0;
    chk("b2b_end", 64'(o_valid), 64'd0);

    d = '0;
    for (int k = 0; k < 31; k++) d[32*k +: 32] = 32'hB000 + k;
    wr(12'd20, d);
    rd_chk("quad", 12'd20, 1'b1, d, word_idx(3, OFF_COL));
    chk("quad_offcol", 64'(o_data[32*30 +: 32]), 64'hB01E);

    rd_valid = 1'b1; rd_tag = 12'd20;
    cyc();
    rd_valid = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    chk("rstmid_oval", 64'(o_valid), 64'd0);
    chk("rstmid_busy", 64'(o_busy), 64'd1);
    chk("rstmid_ready", 64'(o_wready), 64'd0);
    @(negedge clock);
    rst_b = 1'b1;
    wait_idle("sweep_b2", 1000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
